// File: rtl/phone_dial_sequencer.sv
// Dials a stored phone number out one digit at a time over a valid/ready handshake,
// with a fixed inter-digit gap, abort support and a sticky error flag for illegal writes.
module phone_dial_sequencer #(
  parameter int NUM_DIGITS = 10,
  parameter int GAP_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_digit_valid,
  input  logic       i_digit_ready,
  output logic [3:0] o_digit,
  output logic [3:0] o_index,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  localparam int              GW          = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   LP_GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]      LP_LAST     = 4'(NUM_DIGITS - 1);
  localparam logic [4:0]      LP_NUM      = 5'(NUM_DIGITS);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_slot [NUM_DIGITS];
  logic [3:0]      r_index;
  logic [GW-1:0]   r_gap;
  logic            r_err;
  logic            w_hs;
  logic            w_start_ok;
  logic            w_wr_ok;
  logic            w_wr_bad;

  always_comb begin
    // abort wins over a same-cycle handshake, so the digit is not counted
    w_hs       = (r_state == ST_SEND) && i_digit_ready && !i_abort;
    w_start_ok = (r_state == ST_IDLE) && i_start;
    w_wr_ok    = (r_state == ST_IDLE) && i_wr_en && (i_wr_data <= 4'd9)
                 && ({1'b0, i_wr_addr} < LP_NUM);
    w_wr_bad   = i_wr_en && !w_wr_ok;
    w_next     = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_SEND;
      ST_SEND: begin
        if (i_abort)            w_next = ST_IDLE;
        else if (i_digit_ready) w_next = (r_index == LP_LAST) ? ST_DONE : ST_GAP;
      end
      ST_GAP: begin
        if (i_abort)            w_next = ST_IDLE;
        else if (r_gap == '0)   w_next = ST_SEND;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_index <= '0;
      r_gap   <= '0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_slot[i] <= '0;
    end else begin
      if (w_wr_ok) r_slot[i_wr_addr] <= i_wr_data;

      if (w_start_ok)    r_err <= 1'b0;
      else if (w_wr_bad) r_err <= 1'b1;

      if (w_start_ok)                          r_index <= '0;
      else if (w_hs && (r_index != LP_LAST))   r_index <= r_index + 4'd1;

      if (w_hs)                                    r_gap <= LP_GAP_LOAD;
      else if ((r_state == ST_GAP) && (r_gap != '0)) r_gap <= r_gap - 1'b1;
    end
  end

  assign o_digit_valid = (r_state == ST_SEND);
  assign o_digit       = (r_state == ST_SEND) ? r_slot[r_index] : '0;
  assign o_index       = r_index;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_err         = r_err;

endmodule

// File: doc/phone_dial_sequencer.md
# phone_dial_sequencer

Controller that sequences a stored phone number out to a downstream digit consumer, one digit at a time. Software or the bench loads the digit slots through a write port and pulses `start`. The block then walks the index from 0 to `NUM_DIGITS-1`, presenting each digit on a valid/ready handshake. Between accepted digits it inserts a fixed inter-digit gap. It is the scheduler that drives the phone-number counter datapath, replacing that counter's free-running stepping with handshaked, abortable dialing.

## Interface

Parameters:
- `NUM_DIGITS`, default 10: number of digit slots dialed per sequence (1..16).
- `GAP_CYCLES`, default 4: idle cycles between an accepted digit and the next valid digit (≥1).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write strobe for a digit slot.
- `wr_addr`  in  4  slot index to write; `wr_addr ≥ NUM_DIGITS` is rejected.
- `wr_data`  in  4  digit value; legal range 0..9.
- `start`  in  1  single-cycle request to begin dialing.
- `abort`  in  1  cancels an active sequence.
- `digit_valid`  out  1  `digit`/`index` are presented to the consumer.
- `digit_ready`  in  1  consumer accepts the digit when high together with `digit_valid`.
- `digit`  out  4  current digit; 0 when `digit_valid`=0.
- `index`  out  4  current slot index (the count).
- `busy`  out  1  a sequence is active (SEND, GAP or DONE).
- `done`  out  1  one-cycle pulse when the last digit has been accepted.
- `err`  out  1  sticky error flag.

## Operation

- Storage: `NUM_DIGITS` x 4-bit register slots; all slots reset to 0.
- Write rules, applied only in IDLE with `wr_en`=1:
  - `wr_data` ≤ 9 and `wr_addr` < `NUM_DIGITS`: the slot is written.
  - Otherwise: the write is dropped and `err` is set.
- `wr_en` in any non-IDLE state: the write is dropped and `err` is set.
- `err` clears only on `rst` or on an accepted `start`.

FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs: `busy`=0, `digit_valid`=0, `index` holds its last value.
  - `start`=1: `index`←0, `err`←0, go to SEND.
  - `start` and `wr_en` in the same cycle: the write completes first, then `start` is accepted.
- SEND:
  - Outputs: `digit_valid`=1, `digit`=slot[`index`].
  - On handshake with `index` = `NUM_DIGITS-1`: go to DONE.
  - On handshake otherwise: `index`←`index`+1, load the gap counter with `GAP_CYCLES-1`, go to GAP.
  - Without a handshake: hold.
- GAP: `digit_valid`=0; decrement the gap counter; at 0 go to SEND.
- DONE: `done`=1, `busy`=1 for exactly one cycle, then go to IDLE.
- Start handling: `start` outside IDLE is ignored and does not set `err`.
- Abort handling:
  - `abort`=1 in SEND, GAP or DONE: go to IDLE next cycle, no `done` pulse, `index` held.
  - `abort` has priority over a same-cycle handshake. That digit counts as not accepted and `index` does not advance.
  - `abort` in IDLE has no effect.
- Slot contents are never modified by sequencing.
- Index arithmetic:
  - `index` is 4-bit and never exceeds `NUM_DIGITS-1`.
  - There is no wrap to 0 inside a sequence. Reset to 0 happens only on `start` or `rst`.
- `rst` mid-sequence: next cycle is IDLE and all outputs return to their reset values.
- Reset values: `digit_valid`=0, `digit`=0, `index`=0, `busy`=0, `done`=0, `err`=0, all slots=0.

## Timing

- All outputs are registered.
- `start` sampled in cycle t: `digit_valid`=1, `index`=0, `busy`=1 in cycle t+1.
- Handshake in cycle t (not the last digit):
  - `digit_valid`=0 for cycles t+1 .. t+`GAP_CYCLES`.
  - The next digit is valid at t+`GAP_CYCLES`+1.
- Last handshake in cycle t: `done`=1 in t+1, `busy`=0 in t+2. A `start` at t+2 is accepted.
- With `digit_ready` held high, `GAP_CYCLES`=4, `NUM_DIGITS`=10 and start at cycle 0:
  - Digit k is valid in cycle 1+5k.
  - `done` in cycle 47, `busy` low in cycle 48.
- `digit_ready` low while valid stalls SEND indefinitely. `digit` and `index` stay stable while stalled.
- `abort` in cycle t: IDLE and `digit_valid`=0 in t+1.

## Test plan

- Load slots 0..9 with 9,8,7,6,5,4,3,2,1,0, hold `digit_ready`=1, start at cycle 0 -> digits 9..0 on indices 0..9 at cycles 1,6,…,46; `done` pulse at cycle 47 only; `busy` low at cycle 48.
- Same load, toggle `digit_ready` (low 3 cycles at every digit) -> each digit held stable while stalled; the sequence of values is unchanged; exactly 10 handshakes; one `done`.
- Write `wr_data`=12 to slot 3, then `wr_addr`=10 -> both dropped, slot 3 keeps its previous value, `err`=1; the next `start` clears `err` to 0.
- Start, `abort` asserted in the same cycle as the 4th handshake (index 3) -> IDLE next cycle, `index` stays 3, no `done`; a later `start` restarts at index 0.
- `start` and `wr_en` pulsed during GAP -> `start` ignored, write dropped, `err`=1, and the sequence completes normally.
- Assert `rst` during SEND at index 5 -> next cycle all outputs are 0 and all slots are 0.
